// File: rtl/median_filter_ctrl.sv
// Sequencing controller for a 3-stage 3x3 median datapath with frame position tracking.
// Optional border bypass enabled by defining MEDIAN_BORDER_BYPASS_EN.
module median_filter_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_center,
  output logic       ldFilter,
  output logic [1:0] selFilter,
  input  logic [7:0] med_in,
  output logic [7:0] out_pixel,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
);

  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ST2,
    ST3,
    CAPT,
    HOLD
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_col;
  logic [RW-1:0]   r_row;
  logic [7:0]      r_pix;
  logic            r_valid;
  logic            r_last;

  logic            w_col_end;
  logic            w_row_end;
  logic            w_bypass;
  logic            w_ld;
  logic [1:0]      w_sel;

  assign w_col_end = (r_col == CW'(IMG_W - 1));
  assign w_row_end = (r_row == RW'(IMG_H - 1));

`ifdef MEDIAN_BORDER_BYPASS_EN
  assign w_bypass = w_col_end || w_row_end ||
                    (r_col == '0) || (r_row == '0);
`else
  logic w_unused_center;
  assign w_unused_center = ^in_center;
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    w_ld  = 1'b0;
    w_sel = 2'd0;
    unique case (r_state)
      IDLE: begin
        if (in_valid && !w_bypass) begin
          w_ld  = 1'b1;
          w_sel = 2'd1;
        end
      end
      ST2: begin
        w_ld  = 1'b1;
        w_sel = 2'd2;
      end
      ST3: begin
        w_ld  = 1'b1;
        w_sel = 2'd3;
      end
      default: begin
        w_ld  = 1'b0;
        w_sel = 2'd0;
      end
    endcase
  end

  // Reset gates the combinational controls so the datapath stops at once.
  assign ldFilter  = rst_n & w_ld;
  assign selFilter = rst_n ? w_sel : 2'd0;
  assign in_ready  = rst_n & (r_state == IDLE);

  assign out_pixel = r_pix;
  assign out_valid = r_valid;
  assign out_last  = r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_col   <= '0;
      r_row   <= '0;
      r_pix   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_last <= w_col_end && w_row_end;
            if (w_col_end) begin
              r_col <= '0;
              r_row <= w_row_end ? '0 : r_row + RW'(1);
            end else begin
              r_col <= r_col + CW'(1);
            end
            if (w_bypass) begin
              r_pix   <= in_center;
              r_valid <= 1'b1;
              r_state <= HOLD;
            end else begin
              r_state <= ST2;
            end
          end
        end
        ST2: r_state <= ST3;
        ST3: r_state <= CAPT;
        CAPT: begin
          r_pix   <= med_in;
          r_valid <= 1'b1;
          r_state <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_median_filter_ctrl.sv
// Bench for median_filter_ctrl: timeline reference model plus directed windows.
// Also covers the MEDIAN_BORDER_BYPASS_EN build.
module tb_median_filter_ctrl;

`ifdef MEDIAN_BORDER_BYPASS_EN
  localparam int W = 4;
  localparam int H = 3;
`else
  localparam int W = 4;
  localparam int H = 2;
`endif
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_center = 8'd0;
  logic       ldFilter;
  logic [1:0] selFilter;
  logic [7:0] med_in;
  logic [7:0] out_pixel;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;

  logic [7:0] win [9];
  logic [7:0] dp_win [9];

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  median_filter_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_center(in_center),
    .ldFilter(ldFilter), .selFilter(selFilter),
    .med_in(med_in),
    .out_pixel(out_pixel), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  function automatic logic [7:0] median9(input logic [7:0] a [9]);
    logic [7:0] q [$];
    for (int j = 0; j < 9; j++) q.push_back(a[j]);
    q.sort();
    return q[4];
  endfunction

  function automatic bit border(input int c, input int r);
`ifdef MEDIAN_BORDER_BYPASS_EN
    return (c == 0) || (c == W - 1) || (r == 0) || (r == H - 1);
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Datapath stand-in: grabs the window on the row stage, emits the
  // median one cycle after the final stage, junk otherwise.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      med_in <= 8'hEE;
    end else begin
      if (ldFilter && selFilter == 2'd1) dp_win <= win;
      med_in <= (ldFilter && selFilter == 2'd3) ? median9(dp_win) : 8'hEE;
    end
  end

  bit         m_busy = 1'b0;
  bit         m_byp = 1'b0;
  bit         m_last = 1'b0;
  int         m_t = 0;
  int         m_col = 0;
  int         m_row = 0;
  logic [7:0] m_pix = 8'd0;

  always @(negedge rst_n) begin
    m_busy = 1'b0;
    m_col  = 0;
    m_row  = 0;
  end

  always @(negedge clk) begin
    int k;
    int first;
    bit e_rdy, e_ld, e_ov;
    logic [1:0] e_sel;
    if (rst_n) begin
      k = cyc - m_t;
      first = m_byp ? 1 : 4;
      e_rdy = !m_busy;
      e_ld = 1'b0;
      e_sel = 2'd0;
      e_ov = 1'b0;
      if (!m_busy) begin
        e_ld = in_valid && !border(m_col, m_row);
        e_sel = e_ld ? 2'd1 : 2'd0;
      end else begin
        if (!m_byp && k == 1) begin e_ld = 1'b1; e_sel = 2'd2; end
        if (!m_byp && k == 2) begin e_ld = 1'b1; e_sel = 2'd3; end
        e_ov = (k >= first);
      end
      if (chk_en) begin
        chk("in_ready", in_ready, e_rdy);
        chk("ldFilter", ldFilter, e_ld);
        chk("selFilter", selFilter, e_sel);
        chk("out_valid", out_valid, e_ov);
        if (e_ov) begin
          chk("out_pixel", out_pixel, m_pix);
          chk("out_last", out_last, m_last);
        end
      end
      if (!m_busy) begin
        if (in_valid) begin
          m_busy = 1'b1;
          m_t = cyc;
          m_byp = border(m_col, m_row);
          m_pix = m_byp ? in_center : median9(win);
          m_last = (m_col == W - 1) && (m_row == H - 1);
          if (m_col == W - 1) begin
            m_col = 0;
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
          end else begin
            m_col = m_col + 1;
          end
        end
      end else if (e_ov && out_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  task automatic load_win(input int idx);
    for (int j = 0; j < 9; j++)
      win[j] = (idx == 0) ? 8'(j + 1) : 8'((idx * 37 + j * 71 + j * j * 13) & 255);
    in_center = (idx == 0) ? 8'hAA : 8'(idx * 17 + 3);
  endtask

  task automatic send(input int idx, input int hold, input bit noisy,
                      output int lat, output logic lst,
                      output logic [7:0] pix);
    int n;
    bit acc;
    load_win(idx);
    in_valid = 1'b1;
    out_ready = 1'b0;
    n = 0;
    acc = 1'b0;
    lat = 0;
    lst = 1'b0;
    pix = 8'd0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      n++;
    end
    if (!acc) begin
      checks++;
      errs++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 50 cycles");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = noisy;
    out_ready = noisy;
    if (noisy) begin
      for (int j = 0; j < 9; j++) win[j] = 8'($urandom);
      in_center = 8'($urandom);
    end
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    pix = out_pixel;
    lst = out_last;
    if (!noisy) begin
      repeat (hold) begin @(posedge clk); #1; end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("ready_after_hs", in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200us");
    $fatal(1);
  end

  initial begin
    int lat;
    logic lst;
    logic [7:0] pix;
    repeat (2) @(posedge clk);
    in_valid = 1'b1;
    #1;
    chk("rst_ld", ldFilter, 0);
    chk("rst_sel", selFilter, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_olast", out_last, 0);
    chk("rst_opix", out_pixel, 0);
    chk_en = 1'b1;

    send(0, 0, 1'b0, lat, lst, pix);
`ifdef MEDIAN_BORDER_BYPASS_EN
    chk("lat_first", lat, 1);
    chk("pix_first", pix, 8'hAA);
`else
    chk("lat_first", lat, 4);
    chk("pix_first", pix, 8'd5);
`endif
    send(1, 10, 1'b0, lat, lst, pix);
    send(2, 0, 1'b1, lat, lst, pix);
    send(3, 3, 1'b0, lat, lst, pix);
    send(4, 0, 1'b1, lat, lst, pix);

    load_win(77);
    in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("st3_ld", ldFilter, 1);
    chk("st3_sel", selFilter, 3);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_ld", ldFilter, 0);
    chk("abort_sel", selFilter, 0);
    chk("abort_ovalid", out_valid, 0);
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    for (int i = 0; i < N; i++) begin
      send(10 + i, i % 3, 1'(i % 2), lat, lst, pix);
      chk("frame_last", lst, (i == N - 1) ? 1 : 0);
    end
    send(50, 0, 1'b0, lat, lst, pix);
    chk("wrap_last", lst, 0);
`ifndef MEDIAN_BORDER_BYPASS_EN
    chk("wrap_lat", lat, 4);
`else
    chk("wrap_lat", lat, 1);
`endif
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/median_filter_ctrl.md
MEDIAN_FILTER_CTRL -- requirements
Module: median_filter_ctrl

Interface
REQ-001 The block SHALL have parameter IMG_W, default 640, meaning image width in pixels (windows per row), 2..4095.
REQ-002 The block SHALL have parameter IMG_H, default 480, meaning image height in rows, 2..4095.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, meaning the upstream 3x3 window on the datapath inputs is valid.
REQ-006 The block SHALL have port in_ready, output, 1, meaning the controller accepts a window this cycle.
REQ-007 The block SHALL have port in_center, input, 8, the centre pixel of the presented window.
REQ-008 The block SHALL have port ldFilter, output, 1, the load enable to the 9-input median datapath.
REQ-009 The block SHALL have port selFilter, output, 2, the datapath stage select: 1 = row sort, 2 = column sort, 3 = final median.
REQ-010 The block SHALL have port med_in, input, 8, the registered median returned by the datapath.
REQ-011 The block SHALL have port out_pixel, output, 8, the filtered pixel.
REQ-012 The block SHALL have port out_valid, output, 1, meaning out_pixel is valid.
REQ-013 The block SHALL have port out_ready, input, 1, meaning downstream accepts out_pixel.
REQ-014 The block SHALL have port out_last, output, 1, meaning out_pixel is the last pixel of the frame; qualified by out_valid.

Function
REQ-015 The FSM SHALL have states IDLE, ST2, ST3, CAPT and HOLD.
REQ-016 in_ready SHALL be 1 only in IDLE; a window is accepted on a cycle where in_valid and in_ready are both 1.
REQ-017 In IDLE, ldFilter SHALL equal in_valid, and selFilter SHALL be 1 when in_valid is 1; on accept, the FSM SHALL go to ST2.
REQ-018 ST2 SHALL drive ldFilter=1, selFilter=2 and go to ST3; ST3 SHALL drive ldFilter=1, selFilter=3 and go to CAPT.
REQ-019 CAPT SHALL drive ldFilter=0, register med_in into out_pixel and go to HOLD.
REQ-020 Whenever ldFilter is 0, selFilter SHALL be 0.
REQ-021 HOLD SHALL assert out_valid and keep out_pixel and out_last stable until out_ready is 1, then go to IDLE.
REQ-022 Latency SHALL be: window accepted in cycle T gives out_valid=1 from cycle T+4; maximum throughput SHALL be one window per 5 cycles.
REQ-023 Column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1) SHALL give the position of the accepted window and SHALL advance on each accept.
REQ-024 col SHALL wrap from IMG_W-1 to 0 and increment row; row SHALL wrap from IMG_H-1 to 0.
REQ-025 out_last SHALL be registered at accept as (col==IMG_W-1 && row==IMG_H-1).
REQ-026 in_valid while not in IDLE SHALL be ignored: no accept, no counter change, and the datapath controls stay as set by the current state.
REQ-027 out_ready while not in HOLD SHALL have no effect.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately set state=IDLE, col=0, row=0, out_pixel=0, out_valid=0, out_last=0 and ldFilter=0, and SHALL force selFilter=0, including mid-operation.
REQ-029 After rst_n is released, the first accepted window SHALL be treated as (col 0, row 0); a partially processed window SHALL be discarded.

Configuration
REQ-030 When macro MEDIAN_BORDER_BYPASS_EN is defined, a window accepted with col==0, col==IMG_W-1, row==0 or row==IMG_H-1 SHALL skip the datapath: ldFilter=0 in the accept cycle, out_pixel<=in_center, and next state HOLD (out_valid from T+1).
REQ-031 When MEDIAN_BORDER_BYPASS_EN is undefined, every window SHALL use the median path, and in_center SHALL be ignored.

Verification
REQ-032 Window 1..9 accepted at T, med_in modelled as 5 at T+3 -> selFilter 1,2,3 at T..T+2, out_pixel=5 with out_valid at T+4, in_ready=0 from T+1 to the output handshake.
REQ-033 out_ready held 0 for 10 cycles in HOLD -> out_pixel is stable and in_ready=0 throughout; a handshake on cycle H gives in_ready=1 at H+1.
REQ-034 IMG_W=4, IMG_H=2, 8 windows -> out_last=1 only on the 8th output; the 9th window is position (0,0).
REQ-035 rst_n pulsed low during ST3 -> ldFilter=0, selFilter=0 and out_valid=0 asynchronously; no output for the aborted window.
REQ-036 With MEDIAN_BORDER_BYPASS_EN, IMG_W=4, IMG_H=3, in_center=0xAA at (0,0) -> out_pixel=0xAA at T+1, ldFilter never 1; the window at (1,1) uses the median path with 4-cycle latency.
